// File: rtl/param_proc_core.sv
// Parametrised multi-cycle processor: FETCH/DECODE/EXEC sequencing of 16-bit
// instructions from an external synchronous instruction memory.
module param_proc_core #(
    parameter int DATA_W   = 8,
    parameter int PC_W     = 8,
    parameter int NUM_REGS = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_imem_en,
    output logic [PC_W-1:0]   o_imem_addr,
    input  logic [15:0]       i_imem_rdata,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_retire,
    output logic              o_illegal,
    output logic              o_flag_z,
    output logic              o_flag_c,
    output logic [PC_W-1:0]   o_dbg_pc,
    input  logic [3:0]        i_dbg_raddr,
    output logic [DATA_W-1:0] o_dbg_rdata
);

    // state  | meaning
    // IDLE   | out of reset, waiting for start
    // FETCH  | imem read issued at pc
    // DECODE | instruction word captured into ir
    // EXEC   | compute, write back, advance pc, retire
    // HALT   | stopped by HALT; registers held until start
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LI   = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_BNZ  = 4'hC;
    localparam logic [3:0] OP_ILLD = 4'hD;
    localparam logic [3:0] OP_ILLE = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              r_state;
    state_t              w_state_next;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     w_pc_next;
    logic [PC_W-1:0]     w_target;
    logic [15:0]         r_ir;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                r_flag_z;
    logic                r_flag_c;
    logic                r_illegal;

    logic [DATA_W-1:0]   w_rf [16];
    logic [3:0]          w_op;
    logic [3:0]          w_rd;
    logic [3:0]          w_rs1;
    logic [3:0]          w_rs2;
    logic [7:0]          w_imm;
    logic [DATA_W-1:0]   w_rd_val;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W-1:0]   w_imm_ext;
    logic [DATA_W-1:0]   w_result;
    logic                w_carry;
    logic                w_we;
    logic                w_upd_z;
    logic                w_upd_c;
    logic                w_is_illegal;

    // Full 16-entry view of the register file; indices past NUM_REGS read 0.
    for (genvar g = 0; g < 16; g++) begin : g_rf
        if (g < NUM_REGS) begin : g_real
            assign w_rf[g] = r_regs[g];
        end else begin : g_zero
            assign w_rf[g] = '0;
        end
    end

    assign w_op      = r_ir[15:12];
    assign w_rd      = r_ir[11:8];
    assign w_rs1     = r_ir[7:4];
    assign w_rs2     = r_ir[3:0];
    assign w_imm     = r_ir[7:0];
    assign w_rd_val  = w_rf[w_rd];
    assign w_a       = w_rf[w_rs1];
    assign w_b       = w_rf[w_rs2];
    assign w_imm_ext = DATA_W'(w_imm);
    assign w_target  = PC_W'(w_imm);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_next = S_FETCH;
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: w_state_next = S_EXEC;
            S_EXEC:   w_state_next = (w_op == OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:   if (i_start) w_state_next = S_FETCH;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_imem_en = 1'b0;
        o_busy    = 1'b0;
        o_halted  = 1'b0;
        o_retire  = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_imem_en = 1'b1;
                o_busy    = 1'b1;
            end
            S_DECODE: o_busy = 1'b1;
            S_EXEC: begin
                o_busy   = 1'b1;
                o_retire = 1'b1;
            end
            S_HALT:  o_halted = 1'b1;
            default: ;
        endcase
    end

    // Operands come from the pre-writeback register values.
    always_comb begin
        w_result     = '0;
        w_carry      = 1'b0;
        w_we         = 1'b0;
        w_upd_z      = 1'b0;
        w_upd_c      = 1'b0;
        w_is_illegal = 1'b0;
        w_pc_next    = r_pc + PC_W'(1);
        case (w_op)
            OP_NOP: ;
            OP_ADD: begin
                {w_carry, w_result} = {1'b0, w_a} + {1'b0, w_b};
                w_we    = 1'b1;
                w_upd_z = 1'b1;
                w_upd_c = 1'b1;
            end
            OP_SUB: begin
                w_result = w_a - w_b;
                w_carry  = (w_a < w_b);
                w_we     = 1'b1;
                w_upd_z  = 1'b1;
                w_upd_c  = 1'b1;
            end
            OP_AND: begin
                w_result = w_a & w_b;
                w_we     = 1'b1;
                w_upd_z  = 1'b1;
            end
            OP_OR: begin
                w_result = w_a | w_b;
                w_we     = 1'b1;
                w_upd_z  = 1'b1;
            end
            OP_XOR: begin
                w_result = w_a ^ w_b;
                w_we     = 1'b1;
                w_upd_z  = 1'b1;
            end
            OP_SHL: begin
                w_result = {w_a[DATA_W-2:0], 1'b0};
                w_carry  = w_a[DATA_W-1];
                w_we     = 1'b1;
                w_upd_z  = 1'b1;
                w_upd_c  = 1'b1;
            end
            OP_SHR: begin
                w_result = {1'b0, w_a[DATA_W-1:1]};
                w_carry  = w_a[0];
                w_we     = 1'b1;
                w_upd_z  = 1'b1;
                w_upd_c  = 1'b1;
            end
            OP_LI: begin
                w_result = w_imm_ext;
                w_we     = 1'b1;
            end
            OP_ADDI: begin
                {w_carry, w_result} = {1'b0, w_rd_val} + {1'b0, w_imm_ext};
                w_we    = 1'b1;
                w_upd_z = 1'b1;
                w_upd_c = 1'b1;
            end
            OP_JMP:  w_pc_next = w_target;
            OP_BZ:   if (w_rd_val == '0) w_pc_next = w_target;
            OP_BNZ:  if (w_rd_val != '0) w_pc_next = w_target;
            OP_ILLD, OP_ILLE: w_is_illegal = 1'b1;
            OP_HALT: w_pc_next = r_pc;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_HALT: if (i_start) r_pc <= '0;
                S_DECODE: r_ir <= i_imem_rdata;
                S_EXEC: begin
                    r_pc <= w_pc_next;
                    if (w_upd_z) r_flag_z <= (w_result == '0);
                    if (w_upd_c) r_flag_c <= w_carry;
                    if (w_is_illegal) r_illegal <= 1'b1;
                    // Writes to indices past NUM_REGS match no entry and vanish.
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (w_we && (w_rd == 4'(i))) r_regs[i] <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_imem_addr = r_pc;
    assign o_dbg_pc    = r_pc;
    assign o_illegal   = r_illegal;
    assign o_flag_z    = r_flag_z;
    assign o_flag_c    = r_flag_c;
    assign o_dbg_rdata = w_rf[i_dbg_raddr];

endmodule

// File: tb/tb_param_proc_core.sv
// Scoreboard bench for param_proc_core: a plain-arithmetic instruction model
// predicts every retirement; a monitor compares pc, flags and all registers.
module tb_param_proc_core;
    localparam int DW    = 8;
    localparam int PCW   = 8;
    localparam int NREGS = 8;
    localparam int DMOD  = 1 << DW;

    typedef struct packed {
        logic [PCW-1:0]   pc;
        logic [PCW-1:0]   npc;
        logic             z;
        logic             c;
        logic             ill;
        logic [16*DW-1:0] regs;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            imem_en;
    logic [PCW-1:0]  imem_addr;
    logic [15:0]     imem_rdata = 16'h0;
    logic            busy, halted, retire, illegal, flag_z, flag_c;
    logic [PCW-1:0]  dbg_pc;
    logic [3:0]      dbg_raddr;
    logic [DW-1:0]   dbg_rdata;

    logic [15:0] mem [256];
    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;
    int          m_regs [16];
    int          m_z, m_c, m_ill, m_pc;

    param_proc_core #(.DATA_W(DW), .PC_W(PCW), .NUM_REGS(NREGS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_imem_en(imem_en), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
        .o_busy(busy), .o_halted(halted), .o_retire(retire), .o_illegal(illegal),
        .o_flag_z(flag_z), .o_flag_c(flag_c), .o_dbg_pc(dbg_pc),
        .i_dbg_raddr(dbg_raddr), .o_dbg_rdata(dbg_rdata)
    );

    always #20 clk = ~clk;

    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int rreg(input int i);
        return (i < NREGS) ? m_regs[i] : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_z = 0; m_c = 0; m_ill = 0; m_pc = 0;
        sb.delete();
    endtask

    // Executes the loaded program from pc 0 to HALT, pushing one record per retire.
    task automatic model_run();
        int pc, op, rd, a, b, imm, res, cc, npc, t, rv;
        bit wr, uz, uc;
        logic [15:0] ins;
        exp_t e;
        pc = 0;
        for (int step = 0; step < 1000; step++) begin
            ins = mem[pc];
            op  = int'(ins[15:12]);
            rd  = int'(ins[11:8]);
            a   = rreg(int'(ins[7:4]));
            b   = rreg(int'(ins[3:0]));
            imm = int'(ins[7:0]);
            res = 0; wr = 0; uz = 0; uc = 0; cc = m_c;
            npc = (pc + 1) % (1 << PCW);
            case (op)
                1:  begin t = a + b; res = t % DMOD; cc = (t >= DMOD) ? 1 : 0; wr = 1; uz = 1; uc = 1; end
                2:  begin res = (a - b + DMOD) % DMOD; cc = (a < b) ? 1 : 0; wr = 1; uz = 1; uc = 1; end
                3:  begin res = a & b; wr = 1; uz = 1; end
                4:  begin res = a | b; wr = 1; uz = 1; end
                5:  begin res = a ^ b; wr = 1; uz = 1; end
                6:  begin res = (a * 2) % DMOD; cc = (a >= DMOD / 2) ? 1 : 0; wr = 1; uz = 1; uc = 1; end
                7:  begin res = a / 2; cc = a % 2; wr = 1; uz = 1; uc = 1; end
                8:  begin res = imm; wr = 1; end
                9:  begin t = rreg(rd) + imm; res = t % DMOD; cc = (t >= DMOD) ? 1 : 0; wr = 1; uz = 1; uc = 1; end
                10: npc = imm % (1 << PCW);
                11: if (rreg(rd) == 0) npc = imm % (1 << PCW);
                12: if (rreg(rd) != 0) npc = imm % (1 << PCW);
                13, 14: m_ill = 1;
                15: npc = pc;
                default: ;
            endcase
            if (wr && rd < NREGS) m_regs[rd] = res;
            if (uz) m_z = (res == 0) ? 1 : 0;
            if (uc) m_c = cc;
            e.pc  = pc[PCW-1:0];
            e.npc = npc[PCW-1:0];
            e.z   = (m_z != 0);
            e.c   = (m_c != 0);
            e.ill = (m_ill != 0);
            for (int i = 0; i < 16; i++) begin
                rv = rreg(i);
                e.regs[i*DW +: DW] = rv[DW-1:0];
            end
            sb.push_back(e);
            pc = npc;
            if (op == 15) break;
        end
        m_pc = pc;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic gen_random();
        int n, op, imm;
        logic [3:0] rd;
        clear_mem();
        n = int'($urandom_range(4, 20));
        for (int pc = 0; pc < n; pc++) begin
            op = int'($urandom_range(0, 14));
            if (op >= 10 && op <= 12) imm = int'($urandom_range(pc + 1, n));
            else imm = int'($urandom_range(0, 255));
            rd = 4'($urandom_range(0, 9));
            mem[pc] = {op[3:0], rd, imm[7:0]};
        end
    endtask

    task automatic run_prog(input bit chk_timing, input bit poke);
        int n_exp, n_ret, cyc;
        logic [15:0] mask;
        chk("sb_empty_before_run", sb.size(), 0);
        model_run();
        n_exp = sb.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; n_ret = 0; mask = '0;
        while (!halted && cyc < 4000) begin
            if (retire) begin
                n_ret++;
                if (cyc < 16) mask[cyc] = 1'b1;
            end
            if (poke) start = (cyc == 4);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("halt_reached", halted, 1);
        if (chk_timing) chk("retire_cycles", mask, 16'h1248);
        chk("retire_count", n_ret, n_exp);
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
        chk("end_busy", busy, 0);
        chk("end_pc", dbg_pc, m_pc);
        chk("end_z", flag_z, m_z);
        chk("end_c", flag_c, m_c);
        chk("end_illegal", illegal, m_ill);
    endtask

    // Monitor: pc at retire, then next pc, flags and every debug register a cycle later.
    initial begin
        exp_t cur;
        bit   pend;
        pend = 0;
        dbg_raddr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0;
                continue;
            end
            if (pend) begin
                pend = 0;
                chk("next_pc", dbg_pc, cur.npc);
                chk("flag_z", flag_z, cur.z);
                chk("flag_c", flag_c, cur.c);
                chk("illegal", illegal, cur.ill);
                for (int i = 0; i < 16; i++) begin
                    dbg_raddr = 4'(i);
                    #1;
                    chk($sformatf("reg%0d", i), dbg_rdata, cur.regs[i*DW +: DW]);
                end
            end
            if (retire) begin
                if (sb.size() == 0) begin
                    chk("retire_with_empty_sb", retire, 0);
                end else begin
                    cur = sb.pop_front();
                    chk("retire_pc", dbg_pc, cur.pc);
                    pend = 1;
                end
            end
        end
    end

    initial begin
        int n_rst_ret;
        rst_n = 1'b0;
        start = 1'b0;
        clear_mem();
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retire", retire, 0);
        chk("rst_imem_en", imem_en, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_z", flag_z, 0);
        chk("rst_c", flag_c, 0);
        chk("rst_pc", dbg_pc, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        // basic program: r3 = 5 + 3
        clear_mem();
        mem[0] = 16'h8105; mem[1] = 16'h8203; mem[2] = 16'h1312; mem[3] = 16'hF000;
        run_prog(1, 0);
        chk("basic_pc", dbg_pc, 3);
        chk("basic_z", flag_z, 0);
        chk("basic_c", flag_c, 0);

        // carry and zero
        clear_mem();
        mem[0] = 16'h81FF; mem[1] = 16'h9101; mem[2] = 16'hF000;
        run_prog(0, 0);
        chk("addi_z", flag_z, 1);
        chk("addi_c", flag_c, 1);

        // borrow
        clear_mem();
        mem[0] = 16'h8102; mem[1] = 16'h8205; mem[2] = 16'h2312; mem[3] = 16'hF000;
        run_prog(0, 0);
        chk("sub_z", flag_z, 0);
        chk("sub_c", flag_c, 1);

        // branch loop, with a start pulse while busy
        clear_mem();
        mem[0] = 16'h8103; mem[1] = 16'h91FF; mem[2] = 16'hC101; mem[3] = 16'hF000;
        run_prog(0, 1);

        // out-of-range register write
        clear_mem();
        mem[0] = 16'h8700; mem[1] = 16'h8955; mem[2] = 16'hF000;
        run_prog(0, 0);

        // pc wrap 0xFF -> 0x00
        clear_mem();
        mem[0] = 16'hC705; mem[1] = 16'h8701; mem[2] = 16'hA0FE;
        mem[8'hFE] = 16'h0000; mem[8'hFF] = 16'h0000;
        run_prog(0, 0);

        // illegal opcode
        clear_mem();
        mem[0] = 16'hD000; mem[1] = 16'h8107; mem[2] = 16'hF000;
        run_prog(0, 0);
        chk("illegal_set", illegal, 1);

        for (int k = 0; k < 10; k++) begin
            gen_random();
            run_prog(0, 0);
        end

        // reset during DECODE
        clear_mem();
        mem[0] = 16'h81AA; mem[1] = 16'hF000;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_imem_en", imem_en, 0);
        chk("pre_rst_retire", retire, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_pc", dbg_pc, 0);
        chk("mid_rst_illegal", illegal, 0);
        chk("mid_rst_z", flag_z, 0);
        chk("mid_rst_c", flag_c, 0);
        n_rst_ret = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (retire) n_rst_ret++;
        end
        chk("mid_rst_retires", n_rst_ret, 0);
        rst_n = 1'b1;
        model_reset();
        clear_mem();
        run_prog(0, 0);

        // restart from HALT keeps registers
        clear_mem();
        mem[0] = 16'h8233;
        run_prog(0, 0);
        clear_mem();
        mem[0] = 16'h1422;
        run_prog(0, 0);

        for (int k = 0; k < 5; k++) begin
            gen_random();
            run_prog(0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_proc_core.md
Name: param_proc_core

Overview:
- Parametrised, multi-cycle successor to the 8-bit single-cycle processor.
- Generic data width, PC width and register count; 16-bit instruction word fetched from an external synchronous instruction memory.
- Adds a FETCH/DECODE/EXEC state machine, start/halt control, Z/C flags, conditional branches, an illegal-opcode flag, a retire pulse and a debug register read port.
- Sits between the instruction ROM/RAM and the system bench/debug logic.

Parameters:
- DATA_W, 8, register/ALU width; legal range 8..32.
- PC_W, 8, program counter and imem address width; legal range 4..16.
- NUM_REGS, 8, number of general registers; legal range 2..16.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; leaves IDLE/HALT and runs from PC 0.
- imem_en  out  1  instruction memory read enable.
- imem_addr  out  PC_W  instruction address (= pc).
- imem_rdata  in  16  instruction word, valid the cycle after imem_en.
- busy  out  1  high in FETCH/DECODE/EXEC.
- halted  out  1  high in HALT.
- retire  out  1  one-cycle pulse per completed instruction.
- illegal  out  1  sticky; set on undefined opcode.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- dbg_pc  out  PC_W  current pc.
- dbg_raddr  in  4  debug register index.
- dbg_rdata  out  DATA_W  combinational register read; 0 if dbg_raddr >= NUM_REGS.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc=0; all registers, flags, illegal, retire, imem_en = 0. Reset mid-instruction aborts it with no writeback.
- States:
  - IDLE: wait for start=1, then go to FETCH with pc=0.
  - FETCH: imem_en=1, imem_addr=pc; go to DECODE.
  - DECODE: latch imem_rdata into ir; go to EXEC.
  - EXEC: compute, write back, update pc, pulse retire; go to FETCH, or HALT on opcode F.
  - HALT: hold all state; start=1 clears pc to 0 and goes to FETCH. Registers are preserved.
- start is ignored while busy. Throughput is 3 cycles per instruction.
- Instruction format: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2, [7:0] imm8.
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd=rs1+rs2.
  - 2 SUB: rd=rs1-rs2.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SHL: rd=rs1<<1.
  - 7 SHR: rd=rs1>>1, logical.
  - 8 LI: rd=zext(imm8).
  - 9 ADDI: rd=rd+zext(imm8).
  - A JMP: pc=imm8.
  - B BZ: if reg[rd]==0, pc=imm8.
  - C BNZ: if reg[rd]!=0, pc=imm8.
  - F HALT.
  - D, E: illegal. Executed as NOP, set illegal, then continue.
- Arithmetic is modulo 2^DATA_W.
- Flags (both flags hold otherwise):
  - Z is updated by ops 1-7 and 9: Z=(result==0).
  - C for ADD/ADDI is the carry-out. C for SUB is the borrow, (rs1<rs2). C for SHL/SHR is the bit shifted out.
  - LI, branches and NOP leave both flags unchanged.
- Register indices >= NUM_REGS read as 0; writes to them are dropped. Debug reads of such indices return 0.
- Branch/jump targets are imm8 truncated to PC_W bits (zero-extended if PC_W>8). A not-taken branch gives pc+1.
- PC wraps from 2^PC_W-1 to 0.
- All registers, including r0, are writable.
- Reading and writing the same register in EXEC uses the old value for operands.

Test Plan:
- Basic program:
  - Stimulus: program 0x8105, 0x8203, 0x1312, 0xF000; pulse start.
  - Required: retire pulses at EXEC cycles 3, 6, 9, 12 after start. Then r3 reads 8 via dbg, halted=1, dbg_pc=3, Z=0, C=0.
- Carry and zero:
  - Stimulus: LI r1,0xFF; ADDI r1,1 (DATA_W=8).
  - Required: r1=0, Z=1, C=1.
  - Stimulus: SUB with r1=2, r2=5.
  - Required: result 0xFD, C=1, Z=0.
- Branch loop:
  - Stimulus: LI r1,3 @0; ADDI r1,0xFF @1; BNZ r1,1 @2; HALT @3.
  - Required: loop runs 3 times, 8 retires total, r1=0, halted.
- Illegal opcode and range checks:
  - Stimulus: 0xD000.
  - Required: illegal=1 and stays 1; execution continues to the next pc.
  - Stimulus: NUM_REGS=4; LI r9,0x55.
  - Required: no register changes; dbg_raddr=9 returns 0.
- Reset mid-operation and wrap:
  - Stimulus: drop rst_n during DECODE.
  - Required: immediately state=IDLE, pc=0, registers 0, no retire.
  - Stimulus: PC_W=4, 16 NOPs.
  - Required: pc wraps 15→0.
- Restart from HALT:
  - Stimulus: pulse start in HALT.
  - Required: fetch resumes at pc 0 and registers keep their values.
  - Stimulus: start while busy.
  - Required: ignored.
